// File: rtl/data_mem_access_unit.sv
// ---------------------------------------------------------------------------
// data_mem_access_unit
//
// Load/store access unit between the multi-cycle CPU MEM state and the data
// RAM. It accepts one request per instruction, builds byte enables and
// lane-replicated write data, runs a req/ack handshake against a wait-stated
// memory and returns sign- or zero-extended load data to write-back.
// The memory is little-endian: byte 0 is bits [7:0] of the word.
//
// Optional feature (compile-time macro MISALIGN_TRAP_EN):
//   defined   : misaligned half/word accesses skip the bus and finish with
//               err=1, load_data=0.
//   undefined : misaligned half/word addresses are aligned down and the
//               access proceeds normally with err=0.
//
// Parameters
//   TIMEOUT       cycles spent in ACCESS without mem_ack before abort (1..255)
//
// Ports
//   clk           in   1   clock, rising edge
//   reset_n       in   1   asynchronous active-low reset
//   i_start       in   1   one-cycle request pulse
//   i_op_load     in   1   access is a load
//   i_op_store    in   1   access is a store (wins if both ops are set)
//   i_size        in   2   00 byte, 01 half, 10/11 word
//   i_sign_ext    in   1   1 sign-extend loads, 0 zero-extend
//   i_addr        in   32  byte address
//   i_store_data  in   32  right-aligned store operand
//   o_busy        out  1   access in progress (cycle after start .. RESP)
//   o_done        out  1   one-cycle completion pulse
//   o_load_data   out  32  extended load result, held until next start
//   o_err         out  1   timeout / misalign flag, valid with o_done
//   o_mem_req     out  1   memory request, held until mem_ack or timeout
//   o_mem_we      out  1   1 store, 0 load
//   o_mem_addr    out  32  word address
//   o_mem_be      out  4   byte enables
//   o_mem_wdata   out  32  lane-replicated store data
//   i_mem_rdata   in   32  read word, sampled with mem_ack
//   i_mem_ack     in   1   memory completion
// ---------------------------------------------------------------------------
module data_mem_access_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_start,
  input  logic        i_op_load,
  input  logic        i_op_store,
  input  logic [1:0]  i_size,
  input  logic        i_sign_ext,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_store_data,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_load_data,
  output logic        o_err,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_ack
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  // Counter value seen in the last allowed ACCESS cycle.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;

  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic        r_sign;
  logic        r_store;
  logic        r_load;
  logic [31:0] r_wdata;
  logic [7:0]  r_cnt;
  logic        r_err;
  logic [31:0] r_load_data;

  logic        w_accept;
  logic        w_op_any;
  logic        w_misalign;
  logic        w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_load_ext;

  // ---------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------

  // Clear the low address bits a half or word access cannot use.
  function automatic logic [31:0] align_addr(input logic [31:0] a,
                                             input logic [1:0]  sz);
    logic [31:0] res;
    case (sz)
      2'b00:   res = a;
      2'b01:   res = {a[31:1], 1'b0};
      default: res = {a[31:2], 2'b00};
    endcase
    return res;
  endfunction

  function automatic logic [3:0] byte_enables(input logic [1:0] lane,
                                              input logic [1:0] sz);
    logic [3:0] res;
    case (sz)
      2'b00:   res = 4'b0001 << lane;
      2'b01:   res = lane[1] ? 4'b1100 : 4'b0011;
      default: res = 4'b1111;
    endcase
    return res;
  endfunction

  // Replicating the operand lets the enables alone pick the target lane.
  function automatic logic [31:0] replicate_wdata(input logic [31:0] d,
                                                  input logic [1:0]  sz);
    logic [31:0] res;
    case (sz)
      2'b00:   res = {4{d[7:0]}};
      2'b01:   res = {2{d[15:0]}};
      default: res = d;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] extract_load(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [1:0]  sz,
                                               input logic        sext);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (sz)
      2'b00:   res = {{24{sext & b[7]}}, b};
      2'b01:   res = {{16{sext & h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // ---------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------
  assign w_accept = (r_state == S_IDLE) && i_start;
  assign w_op_any = i_op_load | i_op_store;

`ifdef MISALIGN_TRAP_EN
  // Size 11 is handled as a word, hence the test on i_size[1].
  assign w_misalign = ((i_size == 2'b01) && i_addr[0]) ||
                      (i_size[1] && (i_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_timeout  = (r_cnt == CNT_LAST);
  assign w_be       = byte_enables(r_addr[1:0], r_size);
  assign w_wdata    = replicate_wdata(r_wdata, r_size);
  assign w_load_ext = extract_load(i_mem_rdata, r_addr[1:0], r_size, r_sign);

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (w_op_any && !w_misalign) begin
            w_next = S_ACCESS;
          end else begin
            w_next = S_RESP;
          end
        end
      end
      S_ACCESS: begin
        // An ack in the final allowed cycle still counts as success.
        if (i_mem_ack || w_timeout) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    o_busy      = 1'b0;
    o_done      = 1'b0;
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_be    = 4'b0000;
    o_mem_wdata = 32'd0;
    o_mem_addr  = {r_addr[31:2], 2'b00};
    o_load_data = r_load_data;
    o_err       = r_err;
    case (r_state)
      S_ACCESS: begin
        o_busy      = 1'b1;
        o_mem_req   = 1'b1;
        o_mem_we    = r_store;
        o_mem_be    = w_be;
        o_mem_wdata = r_store ? w_wdata : 32'd0;
      end
      S_RESP: begin
        o_busy = 1'b1;
        o_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Request capture: everything the bus cycle needs is frozen on start so
  // the mem_* outputs stay stable while the CPU moves on.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr  <= 32'd0;
      r_size  <= 2'b00;
      r_sign  <= 1'b0;
      r_store <= 1'b0;
      r_load  <= 1'b0;
      r_wdata <= 32'd0;
    end else if (w_accept) begin
      r_addr  <= align_addr(i_addr, i_size);
      r_size  <= i_size;
      r_sign  <= i_sign_ext;
      r_store <= i_op_store;
      r_load  <= i_op_load & ~i_op_store;
      r_wdata <= i_store_data;
    end
  end

  // ---------------------------------------------------------------------
  // Timeout counter: zero outside ACCESS, so it starts from zero on entry.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= 8'd0;
    end else if (r_state == S_ACCESS) begin
      r_cnt <= r_cnt + 8'd1;
    end else begin
      r_cnt <= 8'd0;
    end
  end

  // ---------------------------------------------------------------------
  // Result registers: err and load_data settle on entry to RESP and are
  // held afterwards; a completed store leaves load_data as it was.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err       <= 1'b0;
      r_load_data <= 32'd0;
    end else if (w_accept) begin
      if (!w_op_any) begin
        r_err       <= 1'b0;
        r_load_data <= 32'd0;
      end else if (w_misalign) begin
        r_err       <= 1'b1;
        r_load_data <= 32'd0;
      end else begin
        r_err <= 1'b0;
      end
    end else if (r_state == S_ACCESS) begin
      if (i_mem_ack) begin
        r_err <= 1'b0;
        if (r_load) begin
          r_load_data <= w_load_ext;
        end
      end else if (w_timeout) begin
        r_err       <= 1'b1;
        r_load_data <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_access_unit.sv
module tb_data_mem_access_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_start, i_op_load, i_op_store, i_sign_ext, i_mem_ack;
  logic [1:0]  i_size;
  logic [31:0] i_addr, i_store_data, i_mem_rdata;
  logic        o_busy, o_done, o_err, o_mem_req, o_mem_we;
  logic [31:0] o_load_data, o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_be;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] resp_mem [16];   // memory seen by the DUT
  logic [31:0] ref_mem  [16];   // model's view of memory
  logic [31:0] ref_ld;          // model's view of load_data

  data_mem_access_unit #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_op_load(i_op_load),
    .i_op_store(i_op_store), .i_size(i_size), .i_sign_ext(i_sign_ext),
    .i_addr(i_addr), .i_store_data(i_store_data), .o_busy(o_busy),
    .o_done(o_done), .o_load_data(o_load_data), .o_err(o_err),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata), .i_mem_ack(i_mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (arithmetic on the rules) -------------
  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0) return 4'(1 << (a % 4));
    if (sz == 2'd1) return ((a % 4) >= 2) ? 4'd12 : 4'd3;
    return 4'd15;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] sd);
    if (sz == 2'd0) return (sd & 32'hFF) * 32'h0101_0101;
    if (sz == 2'd1) return (sd & 32'hFFFF) * 32'h0001_0001;
    return sd;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] sz,
                                         input logic sx, input logic [31:0] a);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (w >> (8 * (a % 4))) & 32'hFF;
      if (sx && v >= 128) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      if (sx && v >= 32768) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] m_merge(input logic [31:0] w, input logic [31:0] sd,
                                          input logic [1:0] sz, input logic [31:0] a);
    logic [31:0] mask;
    int sh;
    if (sz == 2'd0) begin
      sh = 8 * int'(a % 4);
      mask = 32'hFF << sh;
      return (w & ~mask) | ((sd & 32'hFF) << sh);
    end
    if (sz == 2'd1) begin
      sh = 16 * int'((a / 2) % 2);
      mask = 32'hFFFF << sh;
      return (w & ~mask) | ((sd & 32'hFFFF) << sh);
    end
    return sd;
  endfunction

  function automatic bit m_misalign(input logic [1:0] sz, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
    return (sz == 2'd1 && (a % 2) != 0) || (sz >= 2'd2 && (a % 4) != 0);
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- one access with the bench acting as memory ------------
  task automatic run_access(input logic ld, input logic st, input logic [1:0] sz,
                            input logic sx, input logic [31:0] a, input logic [31:0] sd,
                            input int ack_dly, input bit poke,
                            output logic [31:0] g_ld, output logic [31:0] g_err,
                            output logic [31:0] g_be, output logic [31:0] g_wd,
                            output logic [31:0] g_addr);
    bit op, is_ld, mis, bus, done_seen, saw_req, exp_err;
    int idx, exp_done, cyc;
    logic [31:0] exp_ld, tmp;
    op      = ld | st;
    is_ld   = ld & ~st;
    mis     = op && m_misalign(sz, a);
    bus     = op && !mis;
    idx     = int'(a[5:2]);
    exp_done = !bus ? 1 : ((ack_dly < TMO) ? ack_dly + 2 : TMO + 1);
    exp_err = mis || (bus && ack_dly >= TMO);
    if (!bus || ack_dly >= TMO) exp_ld = 32'd0;
    else if (is_ld)             exp_ld = m_load(ref_mem[idx], sz, sx, a);
    else                        exp_ld = ref_ld;
    if (bus && st && ack_dly < TMO) ref_mem[idx] = m_merge(ref_mem[idx], sd, sz, a);
    ref_ld = exp_ld;
    g_ld = 0; g_err = 0; g_be = 0; g_wd = 0; g_addr = 0;

    @(posedge clk); #1;
    i_start = 1'b1; i_op_load = ld; i_op_store = st; i_size = sz;
    i_sign_ext = sx; i_addr = a; i_store_data = sd; i_mem_ack = 1'b0;
    @(posedge clk); #1;
    // Scramble request inputs: the DUT must work from its captured copy.
    i_start = 1'b0; i_op_load = 1'($urandom); i_op_store = 1'($urandom);
    i_size = 2'($urandom); i_sign_ext = 1'($urandom);
    i_addr = $urandom; i_store_data = $urandom;
    cyc = 1; done_seen = 0; saw_req = 0;
    while (!done_seen && cyc <= TMO + 6) begin
      i_start = (poke && cyc == 1) ? 1'b1 : 1'b0;
      chk_eq("busy", 32'(o_busy), 32'd1);
      if (o_mem_req) begin
        if (!saw_req) begin
          g_be = 32'(o_mem_be); g_wd = o_mem_wdata; g_addr = o_mem_addr;
          chk_eq("mem_addr", o_mem_addr, a & ~32'd3);
          chk_eq("mem_be", 32'(o_mem_be), 32'(m_be(sz, a)));
          chk_eq("mem_we", 32'(o_mem_we), 32'(st));
          if (st) chk_eq("mem_wdata", o_mem_wdata, m_wdata(sz, sd));
        end else begin
          chk_eq("hold_addr", o_mem_addr, g_addr);
          chk_eq("hold_be", 32'(o_mem_be), g_be);
        end
        saw_req = 1;
        if (cyc - 1 == ack_dly) begin
          i_mem_ack = 1'b1;
          i_mem_rdata = resp_mem[idx];
          if (o_mem_we) begin
            tmp = resp_mem[idx];
            for (int b = 0; b < 4; b++)
              if (o_mem_be[b]) tmp[8*b +: 8] = o_mem_wdata[8*b +: 8];
            resp_mem[idx] = tmp;
          end
        end
      end
      if (o_done) begin
        done_seen = 1;
        g_ld = o_load_data; g_err = 32'(o_err);
        chk_eq("done_cycle", 32'(cyc), 32'(exp_done));
        chk_eq("err", 32'(o_err), 32'(exp_err));
        chk_eq("load_data", o_load_data, exp_ld);
      end
      @(posedge clk); #1;
      i_mem_ack = 1'b0; i_mem_rdata = $urandom; cyc++;
    end
    i_start = 1'b0;
    if (!done_seen) begin
      chk_eq("done_missing", 32'd0, 32'd1);
    end else begin
      chk_eq("done_width", 32'(o_done), 32'd0);
      chk_eq("idle_busy", 32'(o_busy), 32'd0);
      chk_eq("idle_req", 32'(o_mem_req), 32'd0);
    end
    chk_eq("req_seen", 32'(saw_req), 32'(bus));
    // A stray ack while idle must be ignored.
    i_mem_ack = 1'($urandom);
  endtask

  logic [31:0] g_ld, g_err, g_be, g_wd, g_addr;

  initial begin
    reset_n = 1'b0; i_start = 0; i_op_load = 0; i_op_store = 0; i_size = 0;
    i_sign_ext = 0; i_addr = 0; i_store_data = 0; i_mem_rdata = 0; i_mem_ack = 0;
    for (int i = 0; i < 16; i++) begin
      resp_mem[i] = $urandom;
      ref_mem[i]  = resp_mem[i];
    end
    ref_ld = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_eq("rst_busy", 32'(o_busy), 32'd0);
    chk_eq("rst_done", 32'(o_done), 32'd0);
    chk_eq("rst_err", 32'(o_err), 32'd0);
    chk_eq("rst_req", 32'(o_mem_req), 32'd0);
    chk_eq("rst_ld", o_load_data, 32'd0);
    chk_eq("rst_be", 32'(o_mem_be), 32'd0);
    reset_n = 1'b1;

    // LW with ack three cycles after start.
    resp_mem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
    run_access(1, 0, 2'b10, 0, 32'h10, 32'd0, 2, 0, g_ld, g_err, g_be, g_wd, g_addr);
    chk_eq("lw_data", g_ld, 32'hDEADBEEF);
    chk_eq("lw_be", g_be, 32'hF);
    chk_eq("lw_err", g_err, 32'd0);

    // LB / LBU from the top lane.
    resp_mem[4] = 32'h80112233; ref_mem[4] = 32'h80112233;
    run_access(1, 0, 2'b00, 1, 32'h13, 32'd0, 0, 0, g_ld, g_err, g_be, g_wd, g_addr);
    chk_eq("lb_data", g_ld, 32'hFFFFFF80);
    chk_eq("lb_be", g_be, 32'h8);
    run_access(1, 0, 2'b00, 0, 32'h13, 32'd0, 1, 0, g_ld, g_err, g_be, g_wd, g_addr);
    chk_eq("lbu_data", g_ld, 32'h00000080);

    // SH to the upper half; load_data keeps the previous load value.
    run_access(0, 1, 2'b01, 0, 32'h22, 32'h0000ABCD, 1, 0, g_ld, g_err, g_be, g_wd, g_addr);
    chk_eq("sh_addr", g_addr, 32'h20);
    chk_eq("sh_be", g_be, 32'hC);
    chk_eq("sh_wdata", g_wd, 32'hABCDABCD);
    chk_eq("sh_ld_kept", g_ld, 32'h00000080);

    // LW with no ack: timeout.
    run_access(1, 0, 2'b10, 0, 32'h10, 32'd0, 100, 0, g_ld, g_err, g_be, g_wd, g_addr);
    chk_eq("tmo_err", g_err, 32'd1);
    chk_eq("tmo_data", g_ld, 32'd0);

    // Misaligned LW; second start while busy.
    run_access(1, 0, 2'b10, 0, 32'h06, 32'd0, 0, 1, g_ld, g_err, g_be, g_wd, g_addr);
`ifdef MISALIGN_TRAP_EN
    chk_eq("mis_err", g_err, 32'd1);
`else
    chk_eq("mis_addr", g_addr, 32'h04);
    chk_eq("mis_err", g_err, 32'd0);
`endif

    // No-op request.
    run_access(0, 0, 2'b10, 0, 32'h08, 32'd0, 0, 0, g_ld, g_err, g_be, g_wd, g_addr);
    chk_eq("noop_data", g_ld, 32'd0);

    // Reset in the middle of an access.
    @(posedge clk); #1;
    i_start = 1; i_op_load = 1; i_op_store = 0; i_size = 2'b10; i_addr = 32'h30; i_mem_ack = 0;
    @(posedge clk); #1;
    i_start = 0;
    chk_eq("mid_req_on", 32'(o_mem_req), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk_eq("mid_req_drop", 32'(o_mem_req), 32'd0);
    chk_eq("mid_busy", 32'(o_busy), 32'd0);
    @(posedge clk); #1;
    chk_eq("mid_no_done", 32'(o_done), 32'd0);
    reset_n = 1'b1;
    ref_ld = 32'd0;
    @(posedge clk); #1;
    chk_eq("post_rst_done", 32'(o_done), 32'd0);
    chk_eq("post_rst_ld", o_load_data, 32'd0);

    // Randomised traffic.
    for (int n = 0; n < 150; n++) begin
      logic ld, st;
      int dly;
      ld = 1'($urandom); st = 1'($urandom);
      dly = int'($urandom_range(0, TMO - 1));
      if (!st && ($urandom % 8) == 0) dly = 100;
      run_access(ld, st, 2'($urandom), 1'($urandom), $urandom, $urandom, dly,
                 1'($urandom), g_ld, g_err, g_be, g_wd, g_addr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
